// File: rtl/ram_bist_ctrl.sv
// March-style RAM self-test: writes the pattern, then its inverse, each XORed with the
// address, reads both back through a one-cycle pipelined compare, and reports a pass/fail verdict.
module ram_bist_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pattern,
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    input  logic [DATA_W-1:0] i_mem_read_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [3:0]        o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] pattern;
    logic              pass_idx;
    logic [ADDR_W-1:0] addr;
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic              last_addr;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a, input logic p);
        logic [DATA_W-1:0] ext;
        ext = '0;
        ext[ADDR_W-1:0] = a;
        return (p ? ~pattern : pattern) ^ ext;
    endfunction

    assign last_addr = (addr == {ADDR_W{1'b1}});
    // Read data for cmp_addr arrives the cycle after its request; pass_idx is still the same pass.
    assign mismatch  = cmp_vld && (i_mem_read_data != exp_word(cmp_addr, pass_idx));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = WRITE;
            WRITE:   if (last_addr) state_nxt = READ;
            READ:    if (last_addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = pass_idx ? DONE : WRITE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            pattern     <= '0;
            pass_idx    <= 1'b0;
            addr        <= '0;
            cmp_vld     <= 1'b0;
            cmp_addr    <= '0;
            o_err_count <= '0;
            o_fail_addr <= '0;
            o_pass      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmp_vld  <= (state == READ);
            cmp_addr <= addr;
            case (state)
                IDLE: if (i_start) begin
                    pattern     <= i_pattern;
                    pass_idx    <= 1'b0;
                    addr        <= '0;
                    o_err_count <= '0;
                    o_fail_addr <= '0;
                    o_pass      <= 1'b0;
                end
                WRITE, READ: addr <= addr + 1'b1;
                DRAIN:       pass_idx <= 1'b1;
                DONE:        o_pass <= (o_err_count == 4'd0);
                default:     ;
            endcase
            // A zero count means no earlier mismatch in this test, so this one is the first.
            if (mismatch) begin
                if (o_err_count != 4'd15) o_err_count <= o_err_count + 4'd1;
                if (o_err_count == 4'd0)  o_fail_addr <= cmp_addr;
            end
        end
    end

    assign o_mem_write_en   = (state == WRITE);
    assign o_mem_addr       = (state == WRITE || state == READ) ? addr : '0;
    assign o_mem_write_data = (state == WRITE) ? exp_word(addr, pass_idx) : '0;
    assign o_busy           = (state != IDLE);
    assign o_done           = (state == DONE);

endmodule
